register_bank: RTL and testbench

Parametrised bank of `DEPTH` independently loadable `WIDTH`-bit registers with one write port, two registered read ports and a global enable. It replaces the single fixed-width load register in the datapath. Unlike that register, it holds its contents when not loaded, tracks per-entry validity and reports occupancy. Upstream logic writes operands by address; downstream units read two operands per cycle.

---
 rtl/register_pkg.sv | 23 ++
 rtl/register_entry.sv | 58 +++++
 rtl/register_bank.sv | 126 ++++++++++++
 tb/tb_register_bank.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// register_pkg
//   Shared constants and helpers for the register bank.
//   - RESET_VALUE_DEFAULT : default contents of every entry after reset or clear
//   - COUNT_MAX_BITS      : widest valid vector count_ones can accept
//   - count_ones()        : population count used for the occupancy output
package register_pkg;

  localparam int unsigned RESET_VALUE_DEFAULT = 0;

  // Callers zero-extend their vector to this width. Banks deeper than this
  // need the constant raised.
  localparam int unsigned COUNT_MAX_BITS = 256;

  function automatic int unsigned count_ones(input logic [COUNT_MAX_BITS-1:0] bits);
    int unsigned n;
    n = 0;
    for (int i = 0; i < COUNT_MAX_BITS; i++) begin
      n += 32'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/register_entry.sv
// register_entry
//   One bank entry: a WIDTH-bit data register plus a valid flag.
//   Ports:
//     clock        in  rising-edge clock
//     reset_n      in  asynchronous active-low reset
//     enable       in  global gate; 0 holds the entry
//     clear        in  synchronous clear, wins over load
//     load         in  write strobe, already decoded for this entry
//     data_input   in  write data
//     data_output  out stored data
//     valid_output out entry holds loaded data
module register_entry
  import register_pkg::*;
#(
  parameter int              WIDTH       = 18,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(RESET_VALUE_DEFAULT)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data_input,
  output logic [WIDTH-1:0] data_output,
  output logic             valid_output
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (enable) begin
      if (clear) begin
        data_d  = RESET_VALUE;
        valid_d = 1'b0;
      end else if (load) begin
        data_d  = data_input;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_output  = data_q;
  assign valid_output = valid_q;

endmodule

// File: rtl/register_bank.sv
// register_bank
//   DEPTH x WIDTH register bank: one write port, two registered read ports
//   with write-to-read bypass, per-entry valid bits and an occupancy count.
//   Ports:
//     clock, reset_n                  clock / asynchronous active-low reset
//     enable                          global gate; 0 freezes all state
//     clear                           synchronous clear-all (beats load)
//     load, write_address, data_input write port
//     read_enable                     updates both read ports
//     read_address_a/_b               read addresses
//     output_data_a/_b                registered read data
//     output_valid_a/_b               read entry held loaded data
//     loaded_count                    number of valid entries
module register_bank
  import register_pkg::*;
#(
  parameter int               WIDTH       = 18,
  parameter int               DEPTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(RESET_VALUE_DEFAULT),
  localparam int              ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [WIDTH-1:0]      data_input,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_address_a,
  input  logic [ADDR_WIDTH-1:0] read_address_b,
  output logic [WIDTH-1:0]      output_data_a,
  output logic [WIDTH-1:0]      output_data_b,
  output logic                  output_valid_a,
  output logic                  output_valid_b,
  output logic [ADDR_WIDTH:0]   loaded_count
);

  logic [WIDTH-1:0] entry_data [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] entry_load;

  logic write_in_range;
  logic write_hit;

  // Widened by one bit so the compare stays meaningful when DEPTH is a power
  // of two (every address then in range).
  assign write_in_range = ({1'b0, write_address} < (ADDR_WIDTH+1)'(DEPTH));
  assign write_hit      = load & ~clear & write_in_range;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign entry_load[gi] = write_hit & (write_address == ADDR_WIDTH'(gi));

    register_entry #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_entry (
      .clock        (clock),
      .reset_n      (reset_n),
      .enable       (enable),
      .clear        (clear),
      .load         (entry_load[gi]),
      .data_input   (data_input),
      .data_output  (entry_data[gi]),
      .valid_output (entry_valid[gi])
    );
  end

  // Read mux for one port, returning {valid, data}. Reflects the state the
  // bank will have after this edge: clear wins, then a same-cycle write to
  // the same address, then the stored entry.
  function automatic logic [WIDTH:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [WIDTH:0] r;
    r = {1'b0, RESET_VALUE};
    if (clear) begin
      r = {1'b0, RESET_VALUE};
    end else if (write_hit && (write_address == addr)) begin
      r = {1'b1, data_input};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr == ADDR_WIDTH'(i)) begin
          r = {entry_valid[i], entry_data[i]};
        end
      end
    end
    return r;
  endfunction

  logic [WIDTH:0]      rd_a_d, rd_a_q;
  logic [WIDTH:0]      rd_b_d, rd_b_q;
  logic [DEPTH-1:0]    valid_next;
  logic [ADDR_WIDTH:0] count_d, count_q;

  always_comb begin
    rd_a_d = read_port(read_address_a);
    rd_b_d = read_port(read_address_b);
  end

  // Count the valid bits as they will be after this edge so the count
  // register moves on the same edge as the entries.
  always_comb begin
    valid_next = clear ? '0 : (entry_valid | entry_load);
    count_d    = (ADDR_WIDTH+1)'(count_ones(COUNT_MAX_BITS'(valid_next)));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_q  <= {1'b0, RESET_VALUE};
      rd_b_q  <= {1'b0, RESET_VALUE};
      count_q <= '0;
    end else if (enable) begin
      if (read_enable) begin
        rd_a_q <= rd_a_d;
        rd_b_q <= rd_b_d;
      end
      count_q <= count_d;
    end
  end

  assign output_data_a  = rd_a_q[WIDTH-1:0];
  assign output_valid_a = rd_a_q[WIDTH];
  assign output_data_b  = rd_b_q[WIDTH-1:0];
  assign output_valid_b = rd_b_q[WIDTH];
  assign loaded_count   = count_q;

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank
//   Drives a DEPTH=8 and a DEPTH=6 bank with the same stimulus and checks
//   both against a per-bank array model after every clock edge.
module tb_register_bank;

  localparam int W = 18;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         en    = 1'b0;
  logic         clr   = 1'b0;
  logic         ld    = 1'b0;
  logic         re    = 1'b0;
  logic [2:0]   wa    = '0;
  logic [2:0]   ra_a  = '0;
  logic [2:0]   ra_b  = '0;
  logic [W-1:0] din   = '0;

  logic [W-1:0] d8a, d8b, d6a, d6b;
  logic         va8, vb8, va6, vb6;
  logic [3:0]   cnt8, cnt6;

  always #5 clk = ~clk;

  register_bank #(.WIDTH(W), .DEPTH(8)) dut8 (
    .clock(clk), .reset_n(rst_n), .enable(en), .clear(clr), .load(ld),
    .write_address(wa), .data_input(din), .read_enable(re),
    .read_address_a(ra_a), .read_address_b(ra_b),
    .output_data_a(d8a), .output_data_b(d8b),
    .output_valid_a(va8), .output_valid_b(vb8), .loaded_count(cnt8)
  );

  register_bank #(.WIDTH(W), .DEPTH(6)) dut6 (
    .clock(clk), .reset_n(rst_n), .enable(en), .clear(clr), .load(ld),
    .write_address(wa), .data_input(din), .read_enable(re),
    .read_address_a(ra_a), .read_address_b(ra_b),
    .output_data_a(d6a), .output_data_b(d6b),
    .output_valid_a(va6), .output_valid_b(vb6), .loaded_count(cnt6)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: index 0 is the 8-deep bank, index 1 the 6-deep bank.
  logic [W-1:0] m_mem [2][8];
  logic         m_vld [2][8];
  logic [W-1:0] m_da [2];
  logic [W-1:0] m_db [2];
  logic         m_va [2];
  logic         m_vb [2];

  function automatic int depth_of(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic void model_reset(input int k);
    for (int i = 0; i < 8; i++) begin
      m_mem[k][i] = '0;
      m_vld[k][i] = 1'b0;
    end
    m_da[k] = '0; m_db[k] = '0; m_va[k] = 1'b0; m_vb[k] = 1'b0;
  endfunction

  function automatic int model_count(input int k);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_vld[k][i]);
    return n;
  endfunction

  // What a read of address ra sees at this edge: {valid, data}.
  function automatic logic [W:0] model_read(input int k, input logic [2:0] ra);
    int dep;
    dep = depth_of(k);
    if (clr) return '0;
    if (ld && int'(wa) < dep && wa == ra) return {1'b1, din};
    if (int'(ra) < dep) return {m_vld[k][ra], m_mem[k][ra]};
    return '0;
  endfunction

  task automatic model_update(input int k);
    logic [W:0] r;
    if (!en) return;
    if (re) begin
      r = model_read(k, ra_a); m_va[k] = r[W]; m_da[k] = r[W-1:0];
      r = model_read(k, ra_b); m_vb[k] = r[W]; m_db[k] = r[W-1:0];
    end
    if (clr) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[k][i] = '0;
        m_vld[k][i] = 1'b0;
      end
    end else if (ld && int'(wa) < depth_of(k)) begin
      m_mem[k][wa] = din;
      m_vld[k][wa] = 1'b1;
    end
  endtask

  task automatic compare_both();
    check_eq("b8_data_a",  32'(d8a),  32'(m_da[0]));
    check_eq("b8_valid_a", 32'(va8),  32'(m_va[0]));
    check_eq("b8_data_b",  32'(d8b),  32'(m_db[0]));
    check_eq("b8_valid_b", 32'(vb8),  32'(m_vb[0]));
    check_eq("b8_count",   32'(cnt8), 32'(model_count(0)));
    check_eq("b6_data_a",  32'(d6a),  32'(m_da[1]));
    check_eq("b6_valid_a", 32'(va6),  32'(m_va[1]));
    check_eq("b6_data_b",  32'(d6b),  32'(m_db[1]));
    check_eq("b6_valid_b", 32'(vb6),  32'(m_vb[1]));
    check_eq("b6_count",   32'(cnt6), 32'(model_count(1)));
  endtask

  // One clock: update the model from the inputs sampled at the edge, then
  // compare just after the edge.
  task automatic tick();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    compare_both();
  endtask

  initial begin
    // Reset: a real falling edge on reset_n, checked before any clock edge.
    #1 rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #2;
    compare_both();
    @(negedge clk) rst_n = 1'b1;

    // Idle reads of 0 and 7.
    en = 1'b1; re = 1'b1; ra_a = 3'd0; ra_b = 3'd7;
    repeat (5) tick();
    check_eq("idle_count", 32'(cnt8), 32'd0);

    // Two writes, then read both back.
    ld = 1'b1; wa = 3'd3; din = 18'h2AAAA; tick();
    wa = 3'd5; din = 18'h33333; tick();
    ld = 1'b0; ra_a = 3'd3; ra_b = 3'd5; tick();
    check_eq("rd_a_3", 32'(d8a), 32'h2AAAA);
    check_eq("rd_b_5", 32'(d8b), 32'h33333);
    check_eq("rd_count2", 32'(cnt8), 32'd2);

    // Entries hold while not loaded.
    repeat (5) tick();
    check_eq("hold_a_3", 32'(d8a), 32'h2AAAA);
    check_eq("hold_valid_b", 32'(vb8), 32'd1);

    // Rewrite keeps the count.
    ld = 1'b1; wa = 3'd3; din = 18'h15555; tick();
    ld = 1'b0;
    check_eq("rewrite_count", 32'(cnt8), 32'd2);
    check_eq("rewrite_bypass", 32'(d8a), 32'h15555);

    // Same-cycle bypass to port a.
    ld = 1'b1; wa = 3'd6; din = 18'h12345; ra_a = 3'd6; tick();
    ld = 1'b0;
    check_eq("bypass_data", 32'(d8a), 32'h12345);
    check_eq("bypass_valid", 32'(va8), 32'd1);
    check_eq("b6_oor_read6", 32'(va6), 32'd0);

    // Clear beats load.
    clr = 1'b1; ld = 1'b1; wa = 3'd1; din = 18'h00FF0; ra_a = 3'd1; tick();
    clr = 1'b0; ld = 1'b0;
    check_eq("clr_data", 32'(d8a), 32'd0);
    check_eq("clr_valid", 32'(va8), 32'd0);
    check_eq("clr_count", 32'(cnt8), 32'd0);
    tick();
    check_eq("clr_entry1_valid", 32'(va8), 32'd0);

    // Global enable low freezes everything.
    ld = 1'b1; wa = 3'd2; din = 18'h0ABCD; ra_a = 3'd2; tick();
    en = 1'b0; clr = 1'b1; wa = 3'd4; din = 18'h3C3C3; ra_a = 3'd4;
    repeat (3) tick();
    check_eq("frz_data", 32'(d8a), 32'h0ABCD);
    check_eq("frz_count", 32'(cnt8), 32'd1);
    en = 1'b1; clr = 1'b0; ld = 1'b0; tick();
    check_eq("frz_entry4_valid", 32'(va8), 32'd0);

    // Address 7 is out of range for the 6-deep bank.
    ld = 1'b1; wa = 3'd7; din = 18'h3FFFF; ra_a = 3'd7; ra_b = 3'd7; tick();
    ld = 1'b0;
    check_eq("b6_oor_data", 32'(d6a), 32'd0);
    check_eq("b6_oor_valid", 32'(va6), 32'd0);
    check_eq("b8_addr7_data", 32'(d8b), 32'h3FFFF);
    tick();
    check_eq("b6_oor_count", 32'(cnt6), 32'd1);

    // Asynchronous reset between edges after three writes.
    ld = 1'b1; ra_a = 3'd0; ra_b = 3'd2;
    for (int i = 0; i < 3; i++) begin
      wa = 3'(i); din = 18'(32'h100 + i); tick();
    end
    ld = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_eq("arst_count", 32'(cnt8), 32'd0);
    check_eq("arst_valid_b", 32'(vb8), 32'd0);
    compare_both();
    @(negedge clk) rst_n = 1'b1;

    // Randomised traffic.
    for (int n = 0; n < 500; n++) begin
      en   = ($urandom_range(0, 7) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      ld   = $urandom_range(0, 1) == 1;
      wa   = 3'($urandom_range(0, 7));
      din  = 18'($urandom);
      re   = ($urandom_range(0, 3) != 0);
      ra_a = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      ra_b = 3'($urandom_range(0, 7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
